// File: rtl/acc_x_responder.sv
// Accelerator-side endpoint of the X offload bus: q/k accept, request queue, in-order p responses.
// Optional macro ACC_X_RESPONDER_BYPASS_EN forwards exec responses straight to the p channel when idle.
module acc_x_responder #(
    parameter int DataWidth = 32,
    parameter int ReqDepth  = 2,
    parameter int RspDepth  = 2,
    parameter int MaxWb     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [31:0]          xq_instr_data_i,
    input  logic [DataWidth-1:0] xq_rs1_i,
    input  logic [DataWidth-1:0] xq_rs2_i,
    input  logic [DataWidth-1:0] xq_rs3_i,
    input  logic [2:0]           xq_rs_valid_i,
    input  logic [1:0]           xq_rd_clean_i,
    input  logic                 xq_valid_i,
    output logic                 xq_ready_o,
    output logic                 xk_accept_o,
    output logic [1:0]           xk_writeback_o,
    output logic [DataWidth-1:0] xp_data0_o,
    output logic [DataWidth-1:0] xp_data1_o,
    output logic                 xp_dual_writeback_o,
    output logic [4:0]           xp_rd_o,
    output logic                 xp_error_o,
    output logic                 xp_valid_o,
    input  logic                 xp_ready_i,
    output logic [31:0]          prd_instr_data_o,
    input  logic                 prd_accept_i,
    input  logic [1:0]           prd_writeback_i,
    input  logic [2:0]           prd_use_rs_i,
    output logic [31:0]          ex_req_instr_o,
    output logic [DataWidth-1:0] ex_req_rs1_o,
    output logic [DataWidth-1:0] ex_req_rs2_o,
    output logic [DataWidth-1:0] ex_req_rs3_o,
    output logic                 ex_req_valid_o,
    input  logic                 ex_req_ready_i,
    input  logic [DataWidth-1:0] ex_rsp_data0_i,
    input  logic [DataWidth-1:0] ex_rsp_data1_i,
    input  logic                 ex_rsp_dual_i,
    input  logic                 ex_rsp_error_i,
    input  logic                 ex_rsp_valid_i,
    output logic                 ex_rsp_ready_o,
    output logic                 orphan_o
);
    localparam int ReqPw = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int RspPw = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int RdPw  = (MaxWb > 1) ? $clog2(MaxWb) : 1;
    localparam int ReqCw = $clog2(ReqDepth + 1);
    localparam int RspCw = $clog2(RspDepth + 1);
    localparam int RdCw  = $clog2(MaxWb + 1);

    typedef struct packed {
        logic [31:0]          instr;
        logic [DataWidth-1:0] rs1;
        logic [DataWidth-1:0] rs2;
        logic [DataWidth-1:0] rs3;
    } req_t;

    typedef struct packed {
        logic [DataWidth-1:0] data0;
        logic [DataWidth-1:0] data1;
        logic                 dual;
        logic                 error;
    } rsp_t;

    req_t       reqMem_q [ReqDepth];
    rsp_t       rspMem_q [RspDepth];
    logic [4:0] rdMem_q  [MaxWb];

    logic [ReqPw-1:0] reqWrPtr_q, reqWrPtr_d, reqRdPtr_q, reqRdPtr_d;
    logic [RspPw-1:0] rspWrPtr_q, rspWrPtr_d, rspRdPtr_q, rspRdPtr_d;
    logic [RdPw-1:0]  rdWrPtr_q, rdWrPtr_d, rdRdPtr_q, rdRdPtr_d;
    logic [ReqCw-1:0] reqCnt_q, reqCnt_d;
    logic [RspCw-1:0] rspCnt_q, rspCnt_d;
    logic [RdCw-1:0]  rdCnt_q, rdCnt_d;
    logic             orphan_q, orphan_d;

    logic reqFull, reqEmpty, rspFull, rspEmpty, rdFull, hasUntagged;
    logic needsWb, accept, reqPush, reqPop, rdPush, rdPop, rspPush, rspPop;
    logic rspAccept, bypassSel;
    req_t reqHead;
    rsp_t rspHead, rspIn;

    assign reqFull     = (reqCnt_q == ReqCw'(ReqDepth));
    assign reqEmpty    = (reqCnt_q == '0);
    assign rspFull     = (rspCnt_q == RspCw'(RspDepth));
    assign rspEmpty    = (rspCnt_q == '0);
    assign rdFull      = (rdCnt_q == RdCw'(MaxWb));
    // Rd tags waiting for a response are those not yet matched by a queued response.
    assign hasUntagged = (int'(rdCnt_q) > int'(rspCnt_q));
    assign needsWb     = (prd_writeback_i != 2'b00);
    assign reqHead     = reqMem_q[reqRdPtr_q];
    assign rspHead     = rspMem_q[rspRdPtr_q];
    assign rspIn       = '{data0: ex_rsp_data0_i, data1: ex_rsp_data1_i,
                           dual: ex_rsp_dual_i, error: ex_rsp_error_i};

`ifdef ACC_X_RESPONDER_BYPASS_EN
    assign bypassSel = rspEmpty && hasUntagged;
`else
    assign bypassSel = 1'b0;
`endif

    always_comb begin
        xq_ready_o = 1'b0;
        if (xq_valid_i) begin
            if (!prd_accept_i) begin
                xq_ready_o = 1'b1;
            end else begin
                xq_ready_o = ((prd_use_rs_i & ~xq_rs_valid_i) == 3'b000)
                          && ((prd_writeback_i & ~xq_rd_clean_i) == 2'b00)
                          && !reqFull && (!needsWb || !rdFull);
            end
        end
    end

    assign accept           = xq_valid_i && xq_ready_o && prd_accept_i;
    assign xk_accept_o      = accept;
    assign xk_writeback_o   = accept ? prd_writeback_i : 2'b00;
    assign prd_instr_data_o = xq_instr_data_i;
    assign reqPush          = accept;
    assign rdPush           = accept && needsWb;

    assign ex_req_valid_o = !reqEmpty;
    assign ex_req_instr_o = reqEmpty ? '0 : reqHead.instr;
    assign ex_req_rs1_o   = reqEmpty ? '0 : reqHead.rs1;
    assign ex_req_rs2_o   = reqEmpty ? '0 : reqHead.rs2;
    assign ex_req_rs3_o   = reqEmpty ? '0 : reqHead.rs3;
    assign reqPop         = ex_req_valid_o && ex_req_ready_i;

    assign ex_rsp_ready_o = !rspFull;
    assign rspAccept      = ex_rsp_valid_i && ex_rsp_ready_o;
    assign orphan_o       = orphan_q;

    always_comb begin
        rsp_t pSrc;
        pSrc       = rspHead;
        xp_valid_o = !rspEmpty;
        rspPush    = rspAccept && hasUntagged;
        rspPop     = xp_valid_o && xp_ready_i;
        rdPop      = rspPop;
        if (bypassSel) begin
            pSrc       = rspIn;
            xp_valid_o = ex_rsp_valid_i;
            rspPush    = rspAccept && !xp_ready_i;
            rspPop     = 1'b0;
            rdPop      = ex_rsp_valid_i && xp_ready_i;
        end
        xp_data0_o          = xp_valid_o ? pSrc.data0 : '0;
        xp_data1_o          = xp_valid_o ? pSrc.data1 : '0;
        xp_dual_writeback_o = xp_valid_o && pSrc.dual;
        xp_error_o          = xp_valid_o && pSrc.error;
        xp_rd_o             = xp_valid_o ? rdMem_q[rdRdPtr_q] : 5'd0;
    end

    always_comb begin
        reqWrPtr_d = reqWrPtr_q;
        reqRdPtr_d = reqRdPtr_q;
        rspWrPtr_d = rspWrPtr_q;
        rspRdPtr_d = rspRdPtr_q;
        rdWrPtr_d  = rdWrPtr_q;
        rdRdPtr_d  = rdRdPtr_q;
        if (reqPush) reqWrPtr_d = (reqWrPtr_q == ReqPw'(ReqDepth - 1)) ? '0 : reqWrPtr_q + 1'b1;
        if (reqPop)  reqRdPtr_d = (reqRdPtr_q == ReqPw'(ReqDepth - 1)) ? '0 : reqRdPtr_q + 1'b1;
        if (rspPush) rspWrPtr_d = (rspWrPtr_q == RspPw'(RspDepth - 1)) ? '0 : rspWrPtr_q + 1'b1;
        if (rspPop)  rspRdPtr_d = (rspRdPtr_q == RspPw'(RspDepth - 1)) ? '0 : rspRdPtr_q + 1'b1;
        if (rdPush)  rdWrPtr_d  = (rdWrPtr_q == RdPw'(MaxWb - 1)) ? '0 : rdWrPtr_q + 1'b1;
        if (rdPop)   rdRdPtr_d  = (rdRdPtr_q == RdPw'(MaxWb - 1)) ? '0 : rdRdPtr_q + 1'b1;
        reqCnt_d = reqCnt_q + ReqCw'(reqPush) - ReqCw'(reqPop);
        rspCnt_d = rspCnt_q + RspCw'(rspPush) - RspCw'(rspPop);
        rdCnt_d  = rdCnt_q + RdCw'(rdPush) - RdCw'(rdPop);
        orphan_d = orphan_q || (rspAccept && !hasUntagged);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            reqWrPtr_q <= '0;
            reqRdPtr_q <= '0;
            rspWrPtr_q <= '0;
            rspRdPtr_q <= '0;
            rdWrPtr_q  <= '0;
            rdRdPtr_q  <= '0;
            reqCnt_q   <= '0;
            rspCnt_q   <= '0;
            rdCnt_q    <= '0;
            orphan_q   <= 1'b0;
        end else begin
            reqWrPtr_q <= reqWrPtr_d;
            reqRdPtr_q <= reqRdPtr_d;
            rspWrPtr_q <= rspWrPtr_d;
            rspRdPtr_q <= rspRdPtr_d;
            rdWrPtr_q  <= rdWrPtr_d;
            rdRdPtr_q  <= rdRdPtr_d;
            reqCnt_q   <= reqCnt_d;
            rspCnt_q   <= rspCnt_d;
            rdCnt_q    <= rdCnt_d;
            orphan_q   <= orphan_d;
        end
    end

    // Storage needs no reset: counters alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (reqPush) reqMem_q[reqWrPtr_q] <= '{instr: xq_instr_data_i, rs1: xq_rs1_i,
                                               rs2: xq_rs2_i, rs3: xq_rs3_i};
        if (rspPush) rspMem_q[rspWrPtr_q] <= rspIn;
        if (rdPush)  rdMem_q[rdWrPtr_q]   <= xq_instr_data_i[11:7];
    end
endmodule

// File: tb/tb_acc_x_responder.sv
// Directed self-checking bench for acc_x_responder (default build, registered response path).
module tb_acc_x_responder;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [31:0]   xq_instr_data_i;
    logic [DW-1:0] xq_rs1_i, xq_rs2_i, xq_rs3_i;
    logic [2:0]    xq_rs_valid_i;
    logic [1:0]    xq_rd_clean_i;
    logic          xq_valid_i, xq_ready_o, xk_accept_o;
    logic [1:0]    xk_writeback_o;
    logic [DW-1:0] xp_data0_o, xp_data1_o;
    logic          xp_dual_writeback_o, xp_error_o, xp_valid_o, xp_ready_i;
    logic [4:0]    xp_rd_o;
    logic [31:0]   prd_instr_data_o;
    logic          prd_accept_i;
    logic [1:0]    prd_writeback_i;
    logic [2:0]    prd_use_rs_i;
    logic [31:0]   ex_req_instr_o;
    logic [DW-1:0] ex_req_rs1_o, ex_req_rs2_o, ex_req_rs3_o;
    logic          ex_req_valid_o, ex_req_ready_i;
    logic [DW-1:0] ex_rsp_data0_i, ex_rsp_data1_i;
    logic          ex_rsp_dual_i, ex_rsp_error_i, ex_rsp_valid_i, ex_rsp_ready_o;
    logic          orphan_o;

    int compareCount  = 0;
    int mismatchCount = 0;

    always #5 clk_i = ~clk_i;

    acc_x_responder #(.DataWidth(DW), .ReqDepth(2), .RspDepth(2), .MaxWb(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .xq_instr_data_i(xq_instr_data_i), .xq_rs1_i(xq_rs1_i), .xq_rs2_i(xq_rs2_i),
        .xq_rs3_i(xq_rs3_i), .xq_rs_valid_i(xq_rs_valid_i), .xq_rd_clean_i(xq_rd_clean_i),
        .xq_valid_i(xq_valid_i), .xq_ready_o(xq_ready_o), .xk_accept_o(xk_accept_o),
        .xk_writeback_o(xk_writeback_o), .xp_data0_o(xp_data0_o), .xp_data1_o(xp_data1_o),
        .xp_dual_writeback_o(xp_dual_writeback_o), .xp_rd_o(xp_rd_o), .xp_error_o(xp_error_o),
        .xp_valid_o(xp_valid_o), .xp_ready_i(xp_ready_i), .prd_instr_data_o(prd_instr_data_o),
        .prd_accept_i(prd_accept_i), .prd_writeback_i(prd_writeback_i),
        .prd_use_rs_i(prd_use_rs_i), .ex_req_instr_o(ex_req_instr_o),
        .ex_req_rs1_o(ex_req_rs1_o), .ex_req_rs2_o(ex_req_rs2_o), .ex_req_rs3_o(ex_req_rs3_o),
        .ex_req_valid_o(ex_req_valid_o), .ex_req_ready_i(ex_req_ready_i),
        .ex_rsp_data0_i(ex_rsp_data0_i), .ex_rsp_data1_i(ex_rsp_data1_i),
        .ex_rsp_dual_i(ex_rsp_dual_i), .ex_rsp_error_i(ex_rsp_error_i),
        .ex_rsp_valid_i(ex_rsp_valid_i), .ex_rsp_ready_o(ex_rsp_ready_o), .orphan_o(orphan_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic acc,
                                 input logic [1:0] wb, input logic [2:0] useRs,
                                 input logic [2:0] rsValid, input logic [1:0] rdClean);
        xq_valid_i      = valid;
        xq_instr_data_i = instr;
        prd_accept_i    = acc;
        prd_writeback_i = wb;
        prd_use_rs_i    = useRs;
        xq_rs_valid_i   = rsValid;
        xq_rd_clean_i   = rdClean;
    endtask

    task automatic nextCycle();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        xq_rs1_i = 32'h1111_1111; xq_rs2_i = 32'h2222_2222; xq_rs3_i = 32'h3333_3333;
        xp_ready_i = 1'b0; ex_req_ready_i = 1'b0;
        ex_rsp_valid_i = 1'b0; ex_rsp_data0_i = '0; ex_rsp_data1_i = '0;
        ex_rsp_dual_i = 1'b0; ex_rsp_error_i = 1'b0;
        nextCycle(); nextCycle();
        rst_ni = 1'b1;
        settle();
        checkOutput("rst_ex_req_valid", 64'(ex_req_valid_o), 64'd0);
        checkOutput("rst_xp_valid", 64'(xp_valid_o), 64'd0);
        checkOutput("rst_orphan", 64'(orphan_o), 64'd0);
        checkOutput("rst_xq_ready", 64'(xq_ready_o), 64'd0);

        // Reject path
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0033, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        settle();
        checkOutput("rej_ready", 64'(xq_ready_o), 64'd1);
        checkOutput("rej_accept", 64'(xk_accept_o), 64'd0);
        checkOutput("rej_wb", 64'(xk_writeback_o), 64'd0);
        checkOutput("rej_prd_instr", 64'(prd_instr_data_o), 64'h33);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        settle();
        checkOutput("rej_no_req", 64'(ex_req_valid_o), 64'd0);

        // Operand stall, then accept
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h0000_0013, 1'b1, 2'b00, 3'b011, 3'b001, 2'b00);
            settle();
            checkOutput("rs_stall_ready", 64'(xq_ready_o), 64'd0);
        end
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0013, 1'b1, 2'b00, 3'b011, 3'b011, 2'b00);
        settle();
        checkOutput("rs_ok_ready", 64'(xq_ready_o), 64'd1);
        checkOutput("rs_ok_accept", 64'(xk_accept_o), 64'd1);
        checkOutput("rs_ok_req_not_yet", 64'(ex_req_valid_o), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        settle();
        checkOutput("req_valid_next", 64'(ex_req_valid_o), 64'd1);
        checkOutput("req_instr", 64'(ex_req_instr_o), 64'h13);
        checkOutput("req_rs2", 64'(ex_req_rs2_o), 64'h2222_2222);
        ex_req_ready_i = 1'b1;
        nextCycle();
        ex_req_ready_i = 1'b0;
        settle();
        checkOutput("req_popped", 64'(ex_req_valid_o), 64'd0);

        // Write-back to x5 gated by rd_clean
        nextCycle();
        applyStimulus(1'b1, 32'h0000_028B, 1'b1, 2'b01, 3'b000, 3'b000, 2'b00);
        settle();
        checkOutput("wb_unclean_ready", 64'(xq_ready_o), 64'd0);
        nextCycle();
        xq_rd_clean_i = 2'b01;
        settle();
        checkOutput("wb_clean_ready", 64'(xq_ready_o), 64'd1);
        checkOutput("wb_k_writeback", 64'(xk_writeback_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        ex_req_ready_i = 1'b1;
        settle();
        checkOutput("wb_req_valid", 64'(ex_req_valid_o), 64'd1);
        nextCycle();
        ex_req_ready_i = 1'b0;
        ex_rsp_valid_i = 1'b1; ex_rsp_data0_i = 32'hDEAD_BEEF;
        settle();
        checkOutput("wb_rsp_ready", 64'(ex_rsp_ready_o), 64'd1);
        checkOutput("wb_xp_not_yet", 64'(xp_valid_o), 64'd0);
        nextCycle();
        ex_rsp_valid_i = 1'b0;
        settle();
        checkOutput("wb_xp_valid", 64'(xp_valid_o), 64'd1);
        checkOutput("wb_xp_rd", 64'(xp_rd_o), 64'd5);
        checkOutput("wb_xp_data0", 64'(xp_data0_o), 64'hDEAD_BEEF);
        xp_ready_i = 1'b1;
        nextCycle();
        xp_ready_i = 1'b0;
        settle();
        checkOutput("wb_xp_drained", 64'(xp_valid_o), 64'd0);

        // Four outstanding write-backs fill the rd tag FIFO
        ex_req_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            applyStimulus(1'b1, (32'(i) << 7) | 32'h0B, 1'b1, 2'b01, 3'b000, 3'b000, 2'b01);
            settle();
            checkOutput($sformatf("wb4_ready_%0d", i), 64'(xq_ready_o), 64'd1);
        end
        nextCycle();
        applyStimulus(1'b1, 32'h0000_028B, 1'b1, 2'b01, 3'b000, 3'b000, 2'b01);
        settle();
        checkOutput("wb5_stall", 64'(xq_ready_o), 64'd0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        nextCycle();
        ex_req_ready_i = 1'b0;
        ex_rsp_valid_i = 1'b1; ex_rsp_data0_i = 32'h11;
        settle();
        checkOutput("bp_a_rsp_ready", 64'(ex_rsp_ready_o), 64'd1);
        checkOutput("bp_a_xp_valid", 64'(xp_valid_o), 64'd0);
        nextCycle();
        ex_rsp_data0_i = 32'h22;
        settle();
        checkOutput("bp_b_rd", 64'(xp_rd_o), 64'd1);
        checkOutput("bp_b_data", 64'(xp_data0_o), 64'h11);
        nextCycle();
        ex_rsp_valid_i = 1'b0;
        settle();
        checkOutput("bp_c_rsp_full", 64'(ex_rsp_ready_o), 64'd0);
        checkOutput("bp_c_rd_hold", 64'(xp_rd_o), 64'd1);
        checkOutput("bp_c_data_hold", 64'(xp_data0_o), 64'h11);
        nextCycle();
        xp_ready_i = 1'b1;
        settle();
        checkOutput("bp_d_rd", 64'(xp_rd_o), 64'd1);
        nextCycle();
        ex_rsp_valid_i = 1'b1; ex_rsp_data0_i = 32'h33;
        settle();
        checkOutput("bp_e_rd", 64'(xp_rd_o), 64'd2);
        checkOutput("bp_e_data", 64'(xp_data0_o), 64'h22);
        nextCycle();
        ex_rsp_data0_i = 32'h44;
        settle();
        checkOutput("bp_f_rd", 64'(xp_rd_o), 64'd3);
        checkOutput("bp_f_data", 64'(xp_data0_o), 64'h33);
        nextCycle();
        ex_rsp_valid_i = 1'b0;
        settle();
        checkOutput("bp_g_rd", 64'(xp_rd_o), 64'd4);
        checkOutput("bp_g_data", 64'(xp_data0_o), 64'h44);
        nextCycle();
        xp_ready_i = 1'b0;
        settle();
        checkOutput("bp_h_empty", 64'(xp_valid_o), 64'd0);

        // Response with no outstanding write-back
        nextCycle();
        ex_rsp_valid_i = 1'b1; ex_rsp_data0_i = 32'h55;
        settle();
        checkOutput("orph_before", 64'(orphan_o), 64'd0);
        nextCycle();
        ex_rsp_valid_i = 1'b0;
        settle();
        checkOutput("orph_set", 64'(orphan_o), 64'd1);
        checkOutput("orph_no_xp", 64'(xp_valid_o), 64'd0);
        nextCycle(); nextCycle();
        settle();
        checkOutput("orph_sticky", 64'(orphan_o), 64'd1);

        // Reset with a full request queue
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b1, 32'h13 + 32'(i * 128), 1'b1, 2'b00, 3'b000, 3'b000, 2'b00);
            settle();
            checkOutput($sformatf("rq_push_%0d", i), 64'(xq_ready_o), 64'd1);
        end
        nextCycle();
        settle();
        checkOutput("rq_full_stall", 64'(xq_ready_o), 64'd0);
        checkOutput("rq_req_valid", 64'(ex_req_valid_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00);
        rst_ni = 1'b0;
        nextCycle();
        rst_ni = 1'b1;
        settle();
        checkOutput("rq_rst_req_valid", 64'(ex_req_valid_o), 64'd0);
        checkOutput("rq_rst_xp_valid", 64'(xp_valid_o), 64'd0);
        checkOutput("rq_rst_orphan", 64'(orphan_o), 64'd0);
        ex_req_ready_i = 1'b1;
        nextCycle();
        settle();
        checkOutput("rq_rst_stays_empty", 64'(ex_req_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule
